// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a bounded
// memory wait, illegal-instruction detection and a sticky fault encoded in the state.
module multicycle_controller #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        alu_zero,
  input  logic        alu_lt,
  input  logic        alu_ltu,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        IR_WE,
  output logic        PC_WE,
  output logic [1:0]  pc_src,
  output logic [1:0]  ALU_srcA,
  output logic        ALU_srcB,
  output logic [3:0]  ALU_control,
  output logic [2:0]  Imm_sel,
  output logic        RegWE,
  output logic [1:0]  wb_sel,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  localparam int unsigned CNT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Fault cause lives in the state encoding so the state register is the only FSM storage.
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT_ILL, S_FAULT_FETCH, S_FAULT_DATA
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_max;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       rd_nz;
  logic       legal;
  logic       taken;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign funct7      = instr[31:25];
  assign rd_nz       = (instr[11:7] != 5'd0);
  assign wait_max    = (wait_cnt == CNT_W'(MEM_WAIT_MAX));
  assign unused_bits = ^instr[24:15];

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? 4'b0001 : 4'b0000;
      3'b001:  alu_op = 4'b0010;
      3'b010:  alu_op = 4'b0011;
      3'b011:  alu_op = 4'b0100;
      3'b100:  alu_op = 4'b0101;
      3'b101:  alu_op = alt ? 4'b0111 : 4'b0110;
      3'b110:  alu_op = 4'b1000;
      default: alu_op = 4'b1001;
    endcase
  endfunction

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_R:      legal = (funct7 == 7'b0000000) ||
                         ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      OP_I, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
      OP_LOAD:   legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      OP_STORE:  legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      OP_BRANCH: legal = (funct3 != 3'b010) && (funct3 != 3'b011);
      default:   legal = 1'b0;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = alu_zero;
      3'b001:  taken = !alu_zero;
      3'b100:  taken = alu_lt;
      3'b101:  taken = !alu_lt;
      3'b110:  taken = alu_ltu;
      3'b111:  taken = !alu_ltu;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_n;
  end

  // Wait counter restarts on every state change, so entry to FETCH/MEM always sees zero.
  always_ff @(posedge clk) begin
    if (rst)                  wait_cnt <= '0;
    else if (state_n != state) wait_cnt <= '0;
    else if (((state == S_FETCH) || (state == S_MEM)) && !mem_ready)
      wait_cnt <= wait_cnt + CNT_W'(1);
  end

  always_comb begin
    state_n      = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    IR_WE        = 1'b0;
    PC_WE        = 1'b0;
    pc_src       = 2'b00;
    ALU_srcA     = 2'b00;
    ALU_srcB     = 1'b0;
    ALU_control  = 4'b0000;
    Imm_sel      = 3'b000;
    RegWE        = 1'b0;
    wb_sel       = 2'b00;
    fault        = 1'b0;
    fault_cause  = 2'b00;

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          IR_WE   = 1'b1;
          PC_WE   = 1'b1;
          state_n = S_DECODE;
        end else if (wait_max) begin
          state_n = S_FAULT_FETCH;
        end
      end
      S_DECODE: state_n = legal ? S_EXEC : S_FAULT_ILL;
      S_EXEC: begin
        state_n = S_WB;
        case (opcode)
          OP_R: ALU_control = alu_op(funct3, instr[30]);
          OP_I: begin
            ALU_srcB    = 1'b1;
            ALU_control = alu_op(funct3, (funct3 == 3'b101) && instr[30]);
          end
          OP_LOAD, OP_STORE: begin
            ALU_srcB = 1'b1;
            Imm_sel  = (opcode == OP_STORE) ? 3'b001 : 3'b000;
            state_n  = S_MEM;
          end
          OP_BRANCH: begin
            ALU_control = 4'b0001;
            Imm_sel     = 3'b010;
            PC_WE       = taken;
            pc_src      = taken ? 2'b01 : 2'b00;
            state_n     = S_FETCH;
          end
          OP_JAL: begin
            Imm_sel = 3'b100;
            PC_WE   = 1'b1;
            pc_src  = 2'b01;
          end
          OP_JALR: begin
            ALU_srcB = 1'b1;
            PC_WE    = 1'b1;
            pc_src   = 2'b10;
          end
          OP_LUI, OP_AUIPC: begin
            ALU_srcA = (opcode == OP_LUI) ? 2'b10 : 2'b01;
            ALU_srcB = 1'b1;
            Imm_sel  = 3'b011;
          end
          default: state_n = S_FAULT_ILL;
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opcode == OP_STORE);
        if (mem_ready)     state_n = (opcode == OP_STORE) ? S_FETCH : S_WB;
        else if (wait_max) state_n = S_FAULT_DATA;
      end
      S_WB: begin
        RegWE   = rd_nz;
        wb_sel  = (opcode == OP_LOAD) ? 2'b01 :
                  ((opcode == OP_JAL) || (opcode == OP_JALR)) ? 2'b10 : 2'b00;
        state_n = S_FETCH;
      end
      S_FAULT_ILL:   begin fault = 1'b1; fault_cause = 2'b01; end
      S_FAULT_FETCH: begin fault = 1'b1; fault_cause = 2'b10; end
      default:       begin fault = 1'b1; fault_cause = 2'b11; end
    endcase

    // Nothing leaves the controller while reset is held.
    if (rst) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      IR_WE        = 1'b0;
      PC_WE        = 1'b0;
      pc_src       = 2'b00;
      ALU_srcA     = 2'b00;
      ALU_srcB     = 1'b0;
      ALU_control  = 4'b0000;
      Imm_sel      = 3'b000;
      RegWE        = 1'b0;
      wb_sel       = 2'b00;
      fault        = 1'b0;
      fault_cause  = 2'b00;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle vector table plus hand-written
// timeout, illegal-instruction and reset sequences.
module tb_multicycle_controller;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic [1:0] src_a;
    logic       src_b;
    logic [3:0] alu;
    logic [2:0] imm;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       fault;
    logic [1:0] cause;
  } outs_t;

  typedef struct {
    logic [31:0] instr;
    logic        ready;
    logic        z;
    logic        lt;
    logic        ltu;
    outs_t       exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        mem_ready = 1'b0;
  logic        alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, IR_WE, PC_WE, ALU_srcB, RegWE, fault;
  logic [1:0]  pc_src, ALU_srcA, wb_sel, fault_cause;
  logic [3:0]  ALU_control;
  logic [2:0]  Imm_sel;
  outs_t       act;

  int checks = 0;
  int failures = 0;
  vec_t vq[$];

  multicycle_controller #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .IR_WE(IR_WE), .PC_WE(PC_WE), .pc_src(pc_src), .ALU_srcA(ALU_srcA),
    .ALU_srcB(ALU_srcB), .ALU_control(ALU_control), .Imm_sel(Imm_sel),
    .RegWE(RegWE), .wb_sel(wb_sel), .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  assign act = {mem_req, mem_we, mem_addr_sel, IR_WE, PC_WE, pc_src, ALU_srcA, ALU_srcB,
                ALU_control, Imm_sel, RegWE, wb_sel, fault, fault_cause};

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_SRA   = 32'h4020D1B3;
  localparam logic [31:0] I_SRAI  = 32'h4032D293;
  localparam logic [31:0] I_ADDI  = 32'h40000093;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_BLT   = 32'h0020C463;
  localparam logic [31:0] I_BGEU  = 32'h0020F463;
  localparam logic [31:0] I_LW    = 32'h0000A283;
  localparam logic [31:0] I_SW    = 32'h0020A023;
  localparam logic [31:0] I_JAL   = 32'h008000EF;
  localparam logic [31:0] I_JALR  = 32'h00008067;
  localparam logic [31:0] I_LUI   = 32'h123452B7;
  localparam logic [31:0] I_AUIPC = 32'h00000297;

  function automatic outs_t f_fetch(input logic r);
    outs_t o = '0;
    o.mem_req = 1'b1; o.ir_we = r; o.pc_we = r;
    return o;
  endfunction

  function automatic outs_t f_ex(input logic [3:0] alu, input logic [1:0] a, input logic b,
                                 input logic [2:0] imm, input logic pcwe, input logic [1:0] ps);
    outs_t o = '0;
    o.alu = alu; o.src_a = a; o.src_b = b; o.imm = imm; o.pc_we = pcwe; o.pc_src = ps;
    return o;
  endfunction

  function automatic outs_t f_mem(input logic we);
    outs_t o = '0;
    o.mem_req = 1'b1; o.addr_sel = 1'b1; o.mem_we = we;
    return o;
  endfunction

  function automatic outs_t f_wb(input logic we, input logic [1:0] ws);
    outs_t o = '0;
    o.reg_we = we; o.wb_sel = ws;
    return o;
  endfunction

  function automatic outs_t f_fault(input logic [1:0] c);
    outs_t o = '0;
    o.fault = 1'b1; o.cause = c;
    return o;
  endfunction

  function automatic void add(input logic [31:0] i, input logic r, input logic [2:0] fl,
                              input outs_t e);
    vec_t v;
    v.instr = i; v.ready = r; v.z = fl[2]; v.lt = fl[1]; v.ltu = fl[0]; v.exp = e;
    vq.push_back(v);
  endfunction

  function automatic void seq4(input logic [31:0] i, input outs_t ex, input outs_t wb);
    add(i, 1'b1, 3'b000, f_fetch(1'b1));
    add(i, 1'b0, 3'b000, '0);
    add(i, 1'b0, 3'b000, ex);
    add(i, 1'b0, 3'b000, wb);
  endfunction

  function automatic void seq_br(input logic [31:0] i, input logic [2:0] fl, input outs_t ex);
    add(i, 1'b1, fl, f_fetch(1'b1));
    add(i, 1'b0, fl, '0);
    add(i, 1'b0, fl, ex);
  endfunction

  // One clock: drive on the falling edge, compare 1 ns later.
  task automatic cyc(input logic r, input logic [31:0] i, input logic rdy, input logic [2:0] fl,
                     input outs_t e, input string nm);
    @(negedge clk);
    rst = r; instr = i; mem_ready = rdy;
    alu_zero = fl[2]; alu_lt = fl[1]; alu_ltu = fl[0];
    #1;
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, e);
    end
  endtask

  task automatic do_reset();
    cyc(1'b1, I_ADD, 1'b1, 3'b000, '0, "reset_outputs_zero");
    cyc(1'b1, I_ADD, 1'b1, 3'b000, '0, "reset_outputs_zero");
  endtask

  initial begin
    logic [31:0] illegal [5];
    illegal[0] = 32'h0000007F;
    illegal[1] = 32'h402091B3;
    illegal[2] = 32'h0020A463;
    illegal[3] = 32'h0000B283;
    illegal[4] = 32'h0020B023;

    seq4(I_ADD,  f_ex(4'b0000, 2'b00, 1'b0, 3'b000, 1'b0, 2'b00), f_wb(1'b1, 2'b00));
    seq4(I_SUB,  f_ex(4'b0001, 2'b00, 1'b0, 3'b000, 1'b0, 2'b00), f_wb(1'b1, 2'b00));
    seq4(I_SRA,  f_ex(4'b0111, 2'b00, 1'b0, 3'b000, 1'b0, 2'b00), f_wb(1'b1, 2'b00));
    add(I_SRAI, 1'b0, 3'b000, f_fetch(1'b0));
    seq4(I_SRAI, f_ex(4'b0111, 2'b00, 1'b1, 3'b000, 1'b0, 2'b00), f_wb(1'b1, 2'b00));
    seq4(I_ADDI, f_ex(4'b0000, 2'b00, 1'b1, 3'b000, 1'b0, 2'b00), f_wb(1'b1, 2'b00));
    seq_br(I_BEQ,  3'b100, f_ex(4'b0001, 2'b00, 1'b0, 3'b010, 1'b1, 2'b01));
    seq_br(I_BEQ,  3'b000, f_ex(4'b0001, 2'b00, 1'b0, 3'b010, 1'b0, 2'b00));
    seq_br(I_BLT,  3'b010, f_ex(4'b0001, 2'b00, 1'b0, 3'b010, 1'b1, 2'b01));
    seq_br(I_BGEU, 3'b001, f_ex(4'b0001, 2'b00, 1'b0, 3'b010, 1'b0, 2'b00));
    add(I_LW, 1'b1, 3'b000, f_fetch(1'b1));
    add(I_LW, 1'b0, 3'b000, '0);
    add(I_LW, 1'b0, 3'b000, f_ex(4'b0000, 2'b00, 1'b1, 3'b000, 1'b0, 2'b00));
    for (int k = 0; k < 3; k++) add(I_LW, 1'b0, 3'b000, f_mem(1'b0));
    add(I_LW, 1'b1, 3'b000, f_mem(1'b0));
    add(I_LW, 1'b0, 3'b000, f_wb(1'b1, 2'b01));
    add(I_SW, 1'b1, 3'b000, f_fetch(1'b1));
    add(I_SW, 1'b0, 3'b000, '0);
    add(I_SW, 1'b0, 3'b000, f_ex(4'b0000, 2'b00, 1'b1, 3'b001, 1'b0, 2'b00));
    add(I_SW, 1'b1, 3'b000, f_mem(1'b1));
    seq4(I_JAL,   f_ex(4'b0000, 2'b00, 1'b0, 3'b100, 1'b1, 2'b01), f_wb(1'b1, 2'b10));
    seq4(I_JALR,  f_ex(4'b0000, 2'b00, 1'b1, 3'b000, 1'b1, 2'b10), f_wb(1'b0, 2'b10));
    seq4(I_LUI,   f_ex(4'b0000, 2'b10, 1'b1, 3'b011, 1'b0, 2'b00), f_wb(1'b1, 2'b00));
    seq4(I_AUIPC, f_ex(4'b0000, 2'b01, 1'b1, 3'b011, 1'b0, 2'b00), f_wb(1'b1, 2'b00));
    add(I_ADD, 1'b0, 3'b000, f_fetch(1'b0));

    do_reset();
    for (int k = 0; k < vq.size(); k++)
      cyc(1'b0, vq[k].instr, vq[k].ready, {vq[k].z, vq[k].lt, vq[k].ltu}, vq[k].exp,
          $sformatf("vec%0d", k));

    // Illegal encodings fault from DECODE with cause 01 and never write PC/regs.
    for (int k = 0; k < 5; k++) begin
      do_reset();
      cyc(1'b0, illegal[k], 1'b1, 3'b000, f_fetch(1'b1), $sformatf("ill%0d_fetch", k));
      cyc(1'b0, illegal[k], 1'b0, 3'b000, '0, $sformatf("ill%0d_decode", k));
      cyc(1'b0, illegal[k], 1'b1, 3'b000, f_fault(2'b01), $sformatf("ill%0d_fault", k));
      cyc(1'b0, illegal[k], 1'b1, 3'b000, f_fault(2'b01), $sformatf("ill%0d_sticky", k));
    end
    do_reset();
    cyc(1'b0, I_ADD, 1'b0, 3'b000, f_fetch(1'b0), "post_fault_reset_fetch");

    // Fetch timeout: 16 unanswered cycles, then sticky cause 10.
    do_reset();
    for (int k = 0; k < 16; k++)
      cyc(1'b0, I_ADD, 1'b0, 3'b000, f_fetch(1'b0), $sformatf("fto_wait%0d", k));
    for (int k = 0; k < 3; k++)
      cyc(1'b0, I_ADD, 1'b1, 3'b000, f_fault(2'b10), $sformatf("fto_fault%0d", k));

    // Ready on the 16th fetch cycle is still accepted.
    do_reset();
    for (int k = 0; k < 15; k++)
      cyc(1'b0, I_ADD, 1'b0, 3'b000, f_fetch(1'b0), $sformatf("flate_wait%0d", k));
    cyc(1'b0, I_ADD, 1'b1, 3'b000, f_fetch(1'b1), "flate_ready16");
    cyc(1'b0, I_ADD, 1'b0, 3'b000, '0, "flate_decode");
    cyc(1'b0, I_ADD, 1'b0, 3'b000, f_ex(4'b0000, 2'b00, 1'b0, 3'b000, 1'b0, 2'b00), "flate_exec");

    // Data timeout in MEM gives cause 11.
    do_reset();
    cyc(1'b0, I_LW, 1'b1, 3'b000, f_fetch(1'b1), "dto_fetch");
    cyc(1'b0, I_LW, 1'b0, 3'b000, '0, "dto_decode");
    cyc(1'b0, I_LW, 1'b0, 3'b000, f_ex(4'b0000, 2'b00, 1'b1, 3'b000, 1'b0, 2'b00), "dto_exec");
    for (int k = 0; k < 16; k++)
      cyc(1'b0, I_LW, 1'b0, 3'b000, f_mem(1'b0), $sformatf("dto_wait%0d", k));
    for (int k = 0; k < 2; k++)
      cyc(1'b0, I_LW, 1'b1, 3'b000, f_fault(2'b11), $sformatf("dto_fault%0d", k));

    // Reset during WB suppresses the register write and restarts at FETCH.
    do_reset();
    cyc(1'b0, I_ADD, 1'b1, 3'b000, f_fetch(1'b1), "midrst_fetch");
    cyc(1'b0, I_ADD, 1'b0, 3'b000, '0, "midrst_decode");
    cyc(1'b0, I_ADD, 1'b0, 3'b000, f_ex(4'b0000, 2'b00, 1'b0, 3'b000, 1'b0, 2'b00), "midrst_exec");
    cyc(1'b1, I_ADD, 1'b0, 3'b000, '0, "midrst_wb_blocked");
    cyc(1'b0, I_ADD, 1'b0, 3'b000, f_fetch(1'b0), "midrst_refetch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
